clk_div_ctrl: RTL
=================

# clk_div_ctrl

Multi-channel clock-divider controller. It owns `NUM_CH` independent divide counters and accepts run-time divide-ratio updates over a valid/ready configuration port. Each update is applied only at the channel's period boundary, so no runt pulses or glitches appear. Each channel produces a divided clock-enable level and a one-cycle tick strobe that downstream logic uses in place of derived clocks.

## Interface
- `NUM_CH`, 4: number of divider channels (1..16).
- `DIV_W`, 16: divide-ratio width; legal ratios are 2..2^DIV_W-1.
- `clk_in` in 1: single system clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: controller can accept a request for `cfg_ch`.
- `cfg_ch` in $clog2(NUM_CH) (min 1): target channel.
- `cfg_div` in DIV_W: new ratio; 0 = disable channel; 1 = illegal.
- `cfg_err` out 1: one-cycle pulse when a request is rejected.
- `upd_done` out NUM_CH: one-cycle pulse per channel when a new ratio (or disable) takes effect.
- `ch_active` out NUM_CH: channel running.
- `clk_out` out NUM_CH: divided level per channel.
- `tick` out NUM_CH: one-cycle strobe per channel period.

## Operation
- Per-channel state: OFF, RUN, PEND.
  - OFF: channel disabled.
  - RUN: counting with current ratio `div`.
  - PEND: counting; next ratio `nxt` held until the boundary.
- Counter `cnt` runs 0..div-1 and wraps to 0.
  - `tick` = (cnt == div-1) in RUN or PEND.
  - `clk_out` = (cnt < div>>1) in RUN or PEND. Duty is exactly 50% for even div; for odd div the high time is floor(div/2) cycles.
- `cfg_ready` = 0 when `cfg_ch` >= NUM_CH or the addressed channel is in PEND; otherwise 1. It is combinational from `cfg_ch` and state.
- A request is accepted on the edge where `cfg_valid && cfg_ready`.
- `cfg_div` == 1 at acceptance: request is dropped, `cfg_err` pulses the next cycle, and the channel state is unchanged. An out-of-range `cfg_ch` never handshakes; no `cfg_err` is raised.
- OFF + accept with div>=2: → RUN, `div`=cfg_div, `cnt`=0, `upd_done` pulses the next cycle.
- OFF + accept with div=0: stay OFF, `upd_done` pulses (no-op acknowledge).
- RUN + accept (0 or >=2):
  - If `cnt` != div-1: → PEND, `nxt`=cfg_div.
  - If `cnt` == div-1 on that same edge: apply immediately. No extra period, no PEND.
- Apply at boundary (cnt == div-1):
  - `nxt` >= 2: → RUN, `div`=nxt, `cnt`=0.
  - `nxt` = 0: → OFF, `cnt`=0.
  - `upd_done[ch]` pulses in the cycle after the apply edge.
- The tick on the boundary cycle always belongs to the old ratio. The period in progress is never truncated or extended.
- OFF outputs: `cnt`=0, `clk_out`=0, `tick`=0, `ch_active`=0.
- Channels are fully independent; only one configuration is accepted per cycle.

## Timing
- Reset values: all channels OFF, `cnt`=0, `div`=0, `nxt`=0. All outputs are 0 except `cfg_ready`, which follows its equation (1 for legal `cfg_ch`).
- Reset has priority over all activity. Asserting `rst_n`=0 mid-period or while in PEND discards the pending ratio, and no `upd_done` is produced.
- Enable latency: accepted at edge t → `cnt`=0 during cycle t+1, first `tick` in cycle t+div.
- `tick`, `clk_out`, and `ch_active` are registered-state decodes with no combinational path from the cfg inputs.
- `cfg_err` and `upd_done` are registered one-cycle pulses.
- Wrap: `cnt` wraps at div-1. With div = 2^DIV_W-1, `cnt` never reaches 2^DIV_W-1+1, so no overflow is possible.

## Structure
- Package `clk_div_pkg`:
  - `ch_state_e` enum {OFF, RUN, PEND}.
  - `DIV_MIN`=2, `DIV_OFF`=0 constants.
- Sub-module `clk_div_channel`: one instance per channel, generated `NUM_CH` times.
  - Holds state, `cnt`, `div`, `nxt`.
  - Inputs: `load`, `load_div`.
  - Outputs: `busy`, `tick`, `clk_out`, `active`, `done`.
- Top level: `cfg_ready` mux, illegal-ratio check, channel decode, `cfg_err` register.

## Test plan
- Reset, then enable ch0 with div=4 → `clk_out[0]` reads 1,1,0,0 repeating; `tick[0]` in the 4th cycle of each period; `upd_done[0]` pulses one cycle after acceptance.
- ch1 running div=5; request div=2 accepted at cnt=1 → `cfg_ready` for ch1 is low until cnt=4. Current period completes (tick at cnt=4), then period 2 begins; `upd_done[1]` pulses once.
- Request accepted exactly at cnt=div-1 → new ratio applies on that edge; no PEND cycle is observed.
- Request with `cfg_div`=1 → `cfg_err` pulses one cycle, no state change. Request with `cfg_div`=0 on a running channel → channel goes OFF at the boundary; `clk_out`=0 and `tick`=0 afterward.
- `rst_n` driven low for one cycle while ch2 is in PEND → all outputs at reset values on the next cycle; no `upd_done`; the old ratio is not resumed.
- Two channels (div=3 and div=7) updated back-to-back in consecutive cycles → both ratios apply at their own boundaries independently, and no glitches appear on the other channels.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } ch_state_e;

  localparam int unsigned DIV_MIN = 2;
  localparam int unsigned DIV_OFF = 0;

  // Channel-select width; at least one bit even for a single channel.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: free-running counter whose ratio changes only at
// the period boundary (cnt == div-1), so no period is truncated or extended.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             busy,
  output logic             tick,
  output logic             clk_out,
  output logic             active,
  output logic             done
);

  ch_state_e        r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_nxt;
  logic             r_done;

  logic             w_run;
  logic             w_wrap;
  logic             w_apply;
  logic [DIV_W-1:0] w_apply_div;

  assign w_run  = (r_state != OFF);
  assign w_wrap = w_run && (r_cnt == r_div - DIV_W'(1));

  // A new ratio takes effect when enabling from OFF, or at the boundary with
  // either a held ratio (PEND) or one arriving on that very edge (RUN).
  assign w_apply     = ((r_state == OFF) && load) ||
                       (w_wrap && ((r_state == PEND) || load));
  assign w_apply_div = (r_state == PEND) ? r_nxt : load_div;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_div   <= '0;
      r_nxt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_apply;
      if (w_apply) begin
        r_cnt <= '0;
        if (w_apply_div >= DIV_W'(DIV_MIN)) begin
          r_state <= RUN;
          r_div   <= w_apply_div;
        end else begin
          r_state <= OFF;
          r_div   <= DIV_W'(DIV_OFF);
        end
      end else if (w_run) begin
        r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
        if ((r_state == RUN) && load) begin
          r_state <= PEND;
          r_nxt   <= load_div;
        end
      end
    end
  end

  assign busy    = (r_state == PEND);
  assign tick    = w_wrap;
  assign clk_out = w_run && (r_cnt < (r_div >> 1));
  assign active  = w_run;
  assign done    = r_done;

endmodule

// File: rtl/clk_div_ctrl.sv
// Multi-channel clock-divider controller: valid/ready config port, illegal
// ratio rejection, and one boundary-synchronised divider per channel.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned DIV_W  = 16,
  localparam int unsigned CH_W   = ch_idx_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] upd_done,
  output logic [NUM_CH-1:0] ch_active,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_load;
  logic              w_ch_ok;
  logic              w_sel_busy;
  logic              w_accept;
  logic              w_illegal;
  logic              r_cfg_err;

  // Busy flag of the addressed channel; out-of-range selects read as idle.
  always_comb begin
    w_sel_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) w_sel_busy = w_busy[i];
    end
  end

  assign w_ch_ok   = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
  assign cfg_ready = w_ch_ok && !w_sel_busy;
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_illegal = (cfg_div == DIV_W'(1));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_load[g] = w_accept && !w_illegal && (cfg_ch == CH_W'(g));

    clk_div_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .load     (w_load[g]),
      .load_div (cfg_div),
      .busy     (w_busy[g]),
      .tick     (tick[g]),
      .clk_out  (clk_out[g]),
      .active   (ch_active[g]),
      .done     (upd_done[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) r_cfg_err <= 1'b0;
    else        r_cfg_err <= w_accept && w_illegal;
  end

  assign cfg_err = r_cfg_err;

endmodule
